// File: rtl/fp_addsub_unit.sv
// fp_addsub_unit: multi-cycle IEEE-754-style floating-point add/subtract.
// The unit runs one operation at a time: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Special operands (NaN, infinity, both zero) skip straight from ALIGN to DONE.
// Rounding is round-to-nearest-even. Denormal inputs are treated as signed zero.
//
// Ports
//   clock, reset         rising-edge clock; synchronous, active-high reset
//   op1, op2             operands, packed {sign, exponent, fraction}
//   sub                  0: op1+op2, 1: op1-op2 (op2 sign is flipped at capture)
//   input_valid/ready    operand handshake; ready only while IDLE
//   result               packed result
//   result_valid/ready   result handshake; result and flags are held until ready
//   overflow, underflow, invalid, inexact   exception flags, valid with result_valid
module fp_addsub_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  input  logic                   sub,
  input  logic                   input_valid,
  output logic                   input_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid,
  output logic                   inexact
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int EW  = EXP_W + 2;          // exponent with room for carry
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EMAX      = '1;
  localparam logic [EXP_W:0]   SHIFT_MAX = (EXP_W+1)'(SW - 1);
  localparam logic [W-1:0]     QNAN      = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nx;

  // flag vectors are {overflow, underflow, invalid, inexact}
  logic [W-1:0]   a_q, b_q;
  logic           sign_q, eff_sub_q;
  logic [EXP_W-1:0] exp_q;
  logic [SW-1:0]  l_q, s_q;
  logic [SW:0]    sum_q;
  logic [SW-1:0]  nsig_q;
  logic [EW-1:0]  nexp_q;
  logic [W-1:0]   stage_q;
  logic [3:0]     stage_flags_q, flags_q;

  assign input_ready = (state == IDLE);
  assign {overflow, underflow, invalid, inexact} = flags_q;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  // ---------------- ALIGN: classify, order by magnitude, shift the smaller
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special, swap;
  logic [W-2:0]     mag_a, mag_b;
  logic [MAN_W:0]   sig_a, sig_b, sig_l, sig_s;
  logic [EXP_W-1:0] exp_l, exp_s, diff;
  logic             sign_l;
  logic [SW-1:0]    ext_s, al_s;
  logic [W-1:0]     spec_res;
  logic [3:0]       spec_flags;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);
  assign special = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
  // denormals flush to zero, so their fraction never takes part in the math
  assign mag_a = a_zero ? '0 : a_q[W-2:0];
  assign mag_b = b_zero ? '0 : b_q[W-2:0];
  assign sig_a = a_zero ? '0 : {1'b1, fa};
  assign sig_b = b_zero ? '0 : {1'b1, fb};
  assign swap  = (mag_b > mag_a);

  always_comb begin
    sign_l = swap ? sb : sa;
    exp_l  = swap ? eb : ea;
    exp_s  = swap ? ea : eb;
    sig_l  = swap ? sig_b : sig_a;
    sig_s  = swap ? sig_a : sig_b;
    diff   = exp_l - exp_s;
    ext_s  = {sig_s, 3'b000};
    if ({1'b0, diff} >= SHIFT_MAX) begin
      al_s = {{(SW-1){1'b0}}, |sig_s};
    end else begin
      al_s    = ext_s >> diff;
      al_s[0] = al_s[0] | (|(ext_s & ~({SW{1'b1}} << diff)));
    end
  end

  always_comb begin
    spec_flags = 4'b0000;
    if (a_nan | b_nan)                   spec_res = QNAN;
    else if (a_inf & b_inf & (sa ^ sb)) begin
      spec_res   = QNAN;
      spec_flags = 4'b0010;
    end
    else if (a_inf)                      spec_res = {sa, EMAX, {MAN_W{1'b0}}};
    else if (b_inf)                      spec_res = {sb, EMAX, {MAN_W{1'b0}}};
    else                                 spec_res = {sa & sb, {(W-1){1'b0}}};
  end

  // ---------------- NORM
  logic [LZW-1:0] lz;
  logic [EW-1:0]  exp_ext, lz_ext, shamt, n_exp;
  logic [SW-1:0]  n_sig;

  always_comb begin
    lz      = lzc(sum_q[SW-1:0]);
    exp_ext = EW'(exp_q);
    lz_ext  = EW'(lz);
    // never shift the exponent below 1; an unnormalized result means underflow
    shamt   = (lz_ext < exp_ext - EW'(1)) ? lz_ext : exp_ext - EW'(1);
    if (sum_q[SW]) begin
      n_sig = sum_q[SW:1] | SW'(sum_q[0]);
      n_exp = exp_ext + EW'(1);
    end else begin
      n_sig = sum_q[SW-1:0] << shamt;
      n_exp = exp_ext - shamt;
    end
  end

  // ---------------- ROUND
  logic           hidden, g, r, s, rnd_up, frac_c, ovf;
  logic [MAN_W-1:0] frac, frac_rnd;
  logic [EW-1:0]  exp_rnd;
  logic [W-1:0]   rnd_res;
  logic [3:0]     rnd_flags;

  assign hidden = nsig_q[SW-1];
  assign frac   = nsig_q[SW-2:3];
  assign {g, r, s} = nsig_q[2:0];
  assign rnd_up = g & (r | s | nsig_q[3]);
  assign {frac_c, frac_rnd} = {1'b0, frac} + (MAN_W+1)'(rnd_up);
  assign exp_rnd = nexp_q + EW'(frac_c);
  assign ovf     = (exp_rnd >= EW'(EMAX));

  always_comb begin
    rnd_res   = {sign_q, exp_rnd[EXP_W-1:0], frac_rnd};
    rnd_flags = {3'b000, g | r | s};
    if (!hidden) begin
      // shift was clamped at exponent 1: either exact zero or underflow
      if (nsig_q == '0) begin
        rnd_res   = '0;
        rnd_flags = 4'b0000;
      end else begin
        rnd_res   = {sign_q, {(W-1){1'b0}}};
        rnd_flags = 4'b0101;
      end
    end else if (ovf) begin
      rnd_res   = {sign_q, EMAX, {MAN_W{1'b0}}};
      rnd_flags = 4'b1001;
    end
  end

  // ---------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (input_valid) state_nx = ALIGN;
      ALIGN:   state_nx = special ? DONE : ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (result_valid && result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0; b_q <= '0;
      sign_q <= 1'b0; eff_sub_q <= 1'b0; exp_q <= '0;
      l_q <= '0; s_q <= '0; sum_q <= '0;
      nsig_q <= '0; nexp_q <= '0;
      stage_q <= '0; stage_flags_q <= '0;
      result <= '0; flags_q <= '0; result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (input_valid) begin
          a_q <= op1;
          b_q <= {op2[W-1] ^ sub, op2[W-2:0]};
        end
        ALIGN: if (special) begin
          stage_q       <= spec_res;
          stage_flags_q <= spec_flags;
        end else begin
          sign_q    <= sign_l;
          eff_sub_q <= sa ^ sb;
          exp_q     <= exp_l;
          l_q       <= {sig_l, 3'b000};
          s_q       <= al_s;
        end
        // l_q >= s_q by construction, so the difference never goes negative
        ADD: sum_q <= eff_sub_q ? {1'b0, l_q} - {1'b0, s_q} : {1'b0, l_q} + {1'b0, s_q};
        NORM: begin
          nsig_q <= n_sig;
          nexp_q <= n_exp;
        end
        ROUND: begin
          stage_q       <= rnd_res;
          stage_flags_q <= rnd_flags;
        end
        DONE: begin
          if (!result_valid) begin
            result       <= stage_q;
            flags_q      <= stage_flags_q;
            result_valid <= 1'b1;
          end else if (result_ready) begin
            result_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_unit.sv
// Bench for fp_addsub_unit: directed vector table, backpressure and reset
// sequences, a double-precision instance, and random single-precision
// operands checked against an exact-integer reference model.
module tb_fp_addsub_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] op1, op2, res;
  logic sub, in_valid, in_ready, res_valid, res_ready, ovf, unf, inv, inx;
  logic [63:0] d_op1, d_op2, d_res;
  logic d_sub, d_in_valid, d_in_ready, d_res_valid, d_res_ready, d_ovf, d_unf, d_inv, d_inx;

  fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clk), .reset(rst), .op1(op1), .op2(op2), .sub(sub),
    .input_valid(in_valid), .input_ready(in_ready),
    .result(res), .result_valid(res_valid), .result_ready(res_ready),
    .overflow(ovf), .underflow(unf), .invalid(inv), .inexact(inx));

  fp_addsub_unit #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clock(clk), .reset(rst), .op1(d_op1), .op2(d_op2), .sub(d_sub),
    .input_valid(d_in_valid), .input_ready(d_in_ready),
    .result(d_res), .result_valid(d_res_valid), .result_ready(d_res_ready),
    .overflow(d_ovf), .underflow(d_unf), .invalid(d_inv), .inexact(d_inx));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact reference: both operands become signed integers on a common
  // exponent grid, are summed exactly, then rounded to nearest-even.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic [3:0] f);
    logic signed [127:0] va, vb, sm;
    logic [127:0] mag, kept, rem, half;
    int ea, eb, emin, p, e, sh;
    logic neg, up, ix;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    va = (ea == 0) ? 128'sd0 : 128'($unsigned({1'b1, a[22:0]}));
    vb = (eb == 0) ? 128'sd0 : 128'($unsigned({1'b1, b[22:0]}));
    if (ea == 0 && eb == 0) begin
      r = {a[31] & (b[31] ^ s), 31'b0}; f = 4'b0000; return;
    end
    if (ea == 0) ea = eb;
    if (eb == 0) eb = ea;
    emin = (ea < eb) ? ea : eb;
    va = va <<< (ea - emin); vb = vb <<< (eb - emin);
    if (a[31]) va = -va;
    if (b[31] ^ s) vb = -vb;
    sm = va + vb;
    if (sm == 0) begin r = 32'h0; f = 4'b0000; return; end
    neg = sm < 0;
    mag = neg ? 128'(-sm) : 128'(sm);
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = emin + p - 23;
    if (e <= 0) begin r = {neg, 31'b0}; f = 4'b0101; return; end
    up = 1'b0; ix = 1'b0;
    if (p > 23) begin
      sh = p - 23;
      kept = mag >> sh;
      rem = mag - (kept << sh);
      half = 128'(1) << (sh - 1);
      up = (rem > half) || (rem == half && kept[0]);
      ix = (rem != 0);
    end else kept = mag << (23 - p);
    kept = kept + 128'(up);
    if (kept[24]) begin kept = kept >> 1; e++; end
    if (e >= 255) begin r = {neg, 8'hFF, 23'b0}; f = 4'b1001; end
    else begin r = {neg, 8'(e), kept[22:0]}; f = {3'b000, ix}; end
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk); op1 = a; op2 = b; sub = s; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    r = res; f = {ovf, unf, inv, inx};
    res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b; logic s; logic [31:0] r; logic [3:0] f; int lat;
  } vec_t;
  vec_t vecs[15];

  initial begin
    logic [31:0] r, a, b; logic [3:0] f, ef; logic s; int lat, ea, eb;
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 5};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5};
    vecs[2]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 5};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 5};
    vecs[4]  = '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0001, 5};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0010, 2};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001, 5};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2};
    vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 2};
    vecs[11] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010, 2};
    vecs[12] = '{32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 2};
    vecs[13] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101, 5};
    vecs[14] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000, 5};

    rst = 1'b1; op1 = '0; op2 = '0; sub = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    d_op1 = '0; d_op2 = '0; d_sub = 1'b0; d_in_valid = 1'b0; d_res_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset hs32", {in_ready, res_valid}, 2'b10);
    chk("reset res32", res, 32'h0);
    chk("reset flags32", {ovf, unf, inv, inx}, 4'b0);
    chk("reset hs64", {d_in_ready, d_res_valid}, 2'b10);
    chk("reset res64", d_res, 64'h0);
    rst = 1'b0;

    // directed vectors
    for (int i = 0; i < 15; i++) begin
      run32(vecs[i].a, vecs[i].b, vecs[i].s, r, f, lat);
      chk($sformatf("vec%0d result", i), r, vecs[i].r);
      chk($sformatf("vec%0d flags", i), f, vecs[i].f);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d idle", i), {in_ready, res_valid}, 2'b10);
    end

    // backpressure: result held, new operands ignored while busy
    @(negedge clk); op1 = 32'h3F800000; op2 = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp valid", res_valid, 1'b1);
    op1 = 32'h40400000; op2 = 32'h40400000; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp result", res, 32'h40400000);
      chk("bp handshake", {in_ready, res_valid}, 2'b01);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    chk("bp release", {in_ready, res_valid}, 2'b10);
    repeat (8) @(posedge clk); #1;
    chk("bp no ghost", res_valid, 1'b0);

    // reset during NORM aborts both widths
    @(negedge clk);
    op1 = 32'h3F800000; op2 = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
    d_op1 = 64'h3FF0000000000000; d_op2 = 64'h4000000000000000; d_sub = 1'b0; d_in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; d_in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst32 handshake", {in_ready, res_valid}, 2'b10);
    chk("rst64 handshake", {d_in_ready, d_res_valid}, 2'b10);
    repeat (8) @(posedge clk); #1;
    chk("rst32 no result", {res_valid, res}, 33'h0);
    chk("rst64 no result", {d_res_valid, d_res}, 65'h0);

    // double precision 1.0 + 2.0
    @(negedge clk); d_in_valid = 1'b1;
    @(posedge clk); #1; d_in_valid = 1'b0;
    lat = 0;
    while (!d_res_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("dp latency", lat, 5);
    chk("dp result", d_res, 64'h4008000000000000);
    chk("dp flags", {d_ovf, d_unf, d_inv, d_inx}, 4'b0);
    d_res_ready = 1'b1;
    @(posedge clk); #1; d_res_ready = 1'b0;
    chk("dp idle", {d_in_ready, d_res_valid}, 2'b10);

    // random normals (plus zeros), exponent spread bounded so the model stays exact
    for (int k = 0; k < 200; k++) begin
      if (k % 7 == 0)       ea = int'($urandom_range(240, 254));
      else if (k % 11 == 0) ea = int'($urandom_range(1, 12));
      else                  ea = int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      s = 1'($urandom_range(0, 1));
      if (k % 9 == 0) begin b = a ^ 32'($urandom_range(0, 3)); s = ~s; b[31] = a[31] ^ ~s; end
      if (k % 17 == 0) b = {1'($urandom_range(0, 1)), 31'b0};
      model(a, b, s, r, ef);
      run32(a, b, s, op1, f, lat);
      chk($sformatf("rand%0d %h%s%h result", k, a, s ? "-" : "+", b), op1, r);
      chk($sformatf("rand%0d flags", k), f, ef);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fp_addsub_unit.md
Name: fp_addsub_unit

Overview:
- Parametrised multi-cycle IEEE-754-style floating-point add/subtract unit. Successor to the single-precision float adder.
- Generalised over exponent and mantissa width, with an explicit add/subtract mode.
- Valid/ready handshake on both the input and output sides.
- Full special-case handling (zero, infinity, NaN), round-to-nearest-even, and exception flags.
- Sits behind the operand-issue logic; feeds the result writeback stage.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored mantissa (fraction) width; hidden bit is implicit.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Op1  in  1+EXP_W+MAN_W  operand A, packed {sign, exponent, mantissa}.
- Op2  in  1+EXP_W+MAN_W  operand B, same packing.
- Sub  in  1  0 = A+B, 1 = A-B (inverts B sign at capture).
- InputValid  in  1  operands valid.
- InputReady  out  1  unit can accept operands.
- Result  out  1+EXP_W+MAN_W  packed result.
- ResultValid  out  1  Result and flags valid.
- ResultReady  in  1  consumer accepts the result.
- Overflow, Underflow, Invalid, Inexact  out  1 each  exception flags, valid with ResultValid.

Behaviour:
- Clock and reset: one clock (Clock). Reset is synchronous and active-high.
- Reset values: state = IDLE; InputReady = 1; ResultValid = 0; Result = 0; all flags = 0; internal registers cleared.
- Reset mid-operation aborts the in-flight operation; no result is produced.
- Accept: operands, sign-adjusted B and Sub are registered when InputValid && InputReady. InputReady = 1 only in IDLE.
- FSM sequence: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
  - ALIGN: swap so A has the larger magnitude (exponent first, then mantissa). Right-shift the smaller significand by the exponent difference into a {guard, round, sticky} extension.
    - Shift ≥ MAN_W+3 leaves only sticky = OR of the significand.
  - ADD: add or subtract the extended significands according to the effective sign. Result sign = sign of the larger-magnitude operand.
  - NORM:
    - Carry-out: right shift by 1 (lost bit ORed into sticky), exponent + 1.
    - Otherwise: leading-one detect, left shift by min(lz, exp-1), exponent - shift.
  - ROUND: round-to-nearest-even on guard/round/sticky.
    - Mantissa carry out of rounding gives mantissa = 0 and exponent + 1.
    - Exponent reaching all-ones gives ±infinity, Overflow = 1, Inexact = 1.
  - DONE: ResultValid = 1. Result and flags are held stable until ResultReady. The cycle with ResultValid && ResultReady returns to IDLE.
- Latency: ResultValid asserts on the 5th rising edge after the accept edge for normal operands.
- Special cases are detected in ALIGN and jump directly to DONE (ResultValid on the 2nd edge after accept):
  - Any NaN input -> canonical quiet NaN {0, all-ones, 1, 0...}.
  - inf + (-inf) effective -> canonical quiet NaN, Invalid = 1.
  - inf ± finite -> that infinity.
  - Both operands zero -> zero; sign = AND of the signs (+0 unless both are -0).
- Denormal inputs (exponent 0) are flushed to signed zero.
- Exact cancellation (x - x) gives +0.
- Underflow: a normalized exponent ≤ 0 gives a signed zero result, Underflow = 1, and Inexact = 1 if the pre-flush value was nonzero.
- Inexact = 1 whenever guard | round | sticky is set before rounding.
- InputValid while busy is ignored; no capture occurs and no error is flagged.

Test Plan (defaults EXP_W=8, MAN_W=23):
- Basic add: Op1=0x3F800000, Op2=0x40000000, Sub=0 -> Result=0x40400000, all flags 0, ResultValid exactly 5 edges after accept.
- Cancellation: Op1=0x3F800000, Op2=0x3F800000, Sub=1 -> 0x00000000, flags 0. Also check Op1=0x40400000, Op2=0x3F800000, Sub=1 -> 0x40000000.
- Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000, Inexact=1 (tie to even). 0x3F800000 + 0x34400000 -> 0x3F800002, Inexact=1.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, Invalid=1, latency 2.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, Overflow=1, Inexact=1.
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Backpressure: hold ResultReady=0 for 10 cycles -> Result stable, InputReady=0, new InputValid ignored. Release -> IDLE next cycle, InputReady=1.
- Reset mid-op: assert Reset during NORM -> next edge state IDLE, ResultValid=0, InputReady=1. Repeat the run with EXP_W=11, MAN_W=52 and check that 1.0+2.0 = 0x4008000000000000.
